// File: rtl/vend_pkg.sv
// Shared vending types: coin encoding, coin values, dispenser state and the default cent width.
package vend_pkg;

  localparam int unsigned DefaultWidth = 16;

  localparam int unsigned ValDollar  = 100;
  localparam int unsigned ValQuarter = 25;
  localparam int unsigned ValDime    = 10;
  localparam int unsigned ValNickel  = 5;

  typedef enum logic [1:0] {
    CoinDollar  = 2'd0,
    CoinQuarter = 2'd1,
    CoinDime    = 2'd2,
    CoinNickel  = 2'd3
  } coin_e;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEject,
    StDone,
    StFault
  } state_e;

  function automatic int unsigned coin_value(coin_e c);
    int unsigned v;
    case (c)
      CoinDollar:  v = ValDollar;
      CoinQuarter: v = ValQuarter;
      CoinDime:    v = ValDime;
      default:     v = ValNickel;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request and coin-mechanism signals between the change dispenser and its neighbours.
interface change_dispenser_if #(
  parameter int unsigned WIDTH = vend_pkg::DefaultWidth
) ();
  logic [WIDTH-1:0] change_in;
  logic             dispense_req;
  logic             req_ready;
  logic             coin_eject;
  logic [1:0]       coin_type;
  logic             coin_ack;
  logic [3:0]       hopper_empty;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output change_in, dispense_req, coin_ack, hopper_empty,
    input  req_ready, coin_eject, coin_type, remaining, busy, done, error
  );

  modport slave (
    input  change_in, dispense_req, coin_ack, hopper_empty,
    output req_ready, coin_eject, coin_type, remaining, busy, done, error
  );
endinterface

// File: rtl/coin_selector.sv
// Greedy pick: largest available denomination not exceeding the amount still owed.
module coin_selector
  import vend_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] remaining_i,
  input  logic [3:0]       hopper_empty_i,
  output coin_e            coin_type_o,
  output logic             valid_o
);

  // Scan smallest to largest so the largest qualifying coin wins.
  always_comb begin
    valid_o     = 1'b0;
    coin_type_o = CoinDollar;
    for (int i = 3; i >= 0; i--) begin
      if (!hopper_empty_i[i] && (remaining_i >= WIDTH'(coin_value(coin_e'(i[1:0]))))) begin
        valid_o     = 1'b1;
        coin_type_o = coin_e'(i[1:0]);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time over an eject/ack handshake, reporting faults.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned MAX_CHANGE  = 1000
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  state_e           state_q;
  coin_e            coin_type_q;
  logic             coin_eject_q;
  logic [WIDTH-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [CntW-1:0]  cnt_q;

  coin_e sel_type;
  logic  sel_valid;
  logic  req_bad;

  coin_selector #(
    .WIDTH (WIDTH)
  ) u_coin_selector (
    .remaining_i    (remaining_q),
    .hopper_empty_i (bus_io.hopper_empty),
    .coin_type_o    (sel_type),
    .valid_o        (sel_valid)
  );

  assign req_bad = (bus_io.change_in > WIDTH'(MAX_CHANGE)) ||
                   ((bus_io.change_in % WIDTH'(5)) != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      coin_type_q  <= CoinDollar;
      coin_eject_q <= 1'b0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.dispense_req) begin
            remaining_q <= bus_io.change_in;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (req_bad) begin
              state_q <= StFault;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q <= StSelect;
            end
          end
        end
        StSelect: begin
          if (remaining_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (sel_valid) begin
            coin_type_q  <= sel_type;
            coin_eject_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StEject;
          end else begin
            state_q <= StFault;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end
        end
        StEject: begin
          if (bus_io.coin_ack) begin
            remaining_q  <= remaining_q - WIDTH'(coin_value(coin_type_q));
            coin_eject_q <= 1'b0;
            state_q      <= StSelect;
          end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
            coin_eject_q <= 1'b0;
            state_q      <= StFault;
            done_q       <= 1'b1;
            error_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone, StFault: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.req_ready  = ~busy_q;
  assign bus_io.coin_eject = coin_eject_q;
  assign bus_io.coin_type  = coin_type_q;
  assign bus_io.remaining  = remaining_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.error      = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table, corner sequences and random requests vs a model.
module tb_change_dispenser;

  localparam int AckTimeout = 15;

  logic clk;
  logic reset;

  change_dispenser_if #(.WIDTH(16)) dif ();

  change_dispenser #(
    .WIDTH       (16),
    .ACK_TIMEOUT (AckTimeout),
    .MAX_CHANGE  (1000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int got_q[$];
  int exp_q[$];
  int first_ej;
  int done_cyc;
  int max_run;

  typedef struct {
    int         change;
    logic [3:0] he;
    int         d;          // ack delay in eject cycles, -1 = never ack
    int         ncoins;
    int         first_type; // -1 = no coin
    bit         err;
    int         rem;
    int         done_cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: greedy payout from plain arithmetic and cycle accounting.
  task automatic ref_model(input int c, input logic [3:0] he, input int d,
                           output bit err, output int rem, output int dcyc);
    int vals[4];
    int sel;
    int pick;
    vals[0] = 100; vals[1] = 25; vals[2] = 10; vals[3] = 5;
    exp_q.delete();
    rem  = c;
    err  = 1'b0;
    dcyc = -1;
    if (c > 1000 || (c % 5) != 0) begin
      err  = 1'b1;
      dcyc = 1;
      return;
    end
    sel = 1;
    for (int n = 0; n < 1000; n++) begin
      if (rem == 0) begin
        dcyc = sel + 1;
        return;
      end
      pick = -1;
      for (int t = 0; t < 4; t++)
        if (pick < 0 && !he[t] && vals[t] <= rem) pick = t;
      if (pick < 0) begin
        err  = 1'b1;
        dcyc = sel + 1;
        return;
      end
      exp_q.push_back(pick);
      if (d < 0) begin
        err  = 1'b1;
        dcyc = sel + 1 + AckTimeout;
        return;
      end
      rem -= vals[pick];
      sel += d + 2;
    end
  endtask

  // Entered and left at #1 after a rising edge with the block idle.
  task automatic run_txn(input int c, input logic [3:0] he, input int d);
    int h;
    bit seen_done;
    got_q.delete();
    first_ej  = -1;
    done_cyc  = -1;
    max_run   = 0;
    h         = 0;
    seen_done = 1'b0;
    dif.change_in    = 16'(c);
    dif.hopper_empty = he;
    dif.coin_ack     = 1'b0;
    dif.dispense_req = 1'b1;
    @(posedge clk); #1;
    dif.dispense_req = 1'b0;
    for (int k = 1; k <= 3000 && !seen_done; k++) begin
      dif.coin_ack = 1'b0;
      if (dif.coin_eject) begin
        if (h == 0) begin
          got_q.push_back(int'(dif.coin_type));
          if (first_ej < 0) first_ej = k;
        end
        if (d >= 0 && h == d) dif.coin_ack = 1'b1;
        h++;
        if (h > max_run) max_run = h;
      end else begin
        h = 0;
      end
      if (dif.done) begin
        done_cyc  = k;
        seen_done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen_done) check("done_never_seen", 0, 1);
    dif.coin_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_result(input string tag, input bit err, input int rem, input int dcyc);
    check({tag, "_error"}, int'(dif.error), int'(err));
    check({tag, "_remaining"}, int'(dif.remaining), rem);
    check({tag, "_done_cycle"}, done_cyc, dcyc);
    check({tag, "_req_ready"}, int'(dif.req_ready), 1);
    check({tag, "_busy"}, int'(dif.busy), 0);
    check({tag, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_coin_type"}, got_q[i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, int'(dif.req_ready), 1);
    check({tag, "_coin_eject"}, int'(dif.coin_eject), 0);
    check({tag, "_coin_type"}, int'(dif.coin_type), 0);
    check({tag, "_remaining"}, int'(dif.remaining), 0);
    check({tag, "_busy"}, int'(dif.busy), 0);
    check({tag, "_done"}, int'(dif.done), 0);
    check({tag, "_error"}, int'(dif.error), 0);
  endtask

  initial begin
    bit m_err;
    int m_rem;
    int m_dcyc;
    int c;
    int d;
    int ejects;
    int done_k;
    bit prev_ej;
    bit busy_seen;
    logic [3:0] he;

    checks   = 0;
    failures = 0;
    dif.change_in    = '0;
    dif.dispense_req = 1'b0;
    dif.coin_ack     = 1'b0;
    dif.hopper_empty = 4'b0000;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    //         change he       d   n  first err rem   done
    vecs[0]  = '{50,   4'b0000, 1,  2, 1,  1'b0, 0,    8};
    vecs[1]  = '{190,  4'b0000, 0,  6, 0,  1'b0, 0,    14};
    vecs[2]  = '{40,   4'b0010, 0,  4, 2,  1'b0, 0,    10};
    vecs[3]  = '{25,   4'b0000, -1, 1, 1,  1'b1, 25,   17};
    vecs[4]  = '{13,   4'b0000, 0,  0, -1, 1'b1, 13,   1};
    vecs[5]  = '{1005, 4'b0000, 0,  0, -1, 1'b1, 1005, 1};
    vecs[6]  = '{0,    4'b0000, 0,  0, -1, 1'b0, 0,    2};
    vecs[7]  = '{5,    4'b1000, 0,  0, -1, 1'b1, 5,    2};
    vecs[8]  = '{30,   4'b0100, 0,  2, 1,  1'b0, 0,    6};
    vecs[9]  = '{1000, 4'b0000, 0,  10, 0, 1'b0, 0,    22};
    vecs[10] = '{15,   4'b1100, 2,  0, -1, 1'b1, 15,   2};

    for (int v = 0; v < 11; v++) begin
      ref_model(vecs[v].change, vecs[v].he, vecs[v].d, m_err, m_rem, m_dcyc);
      run_txn(vecs[v].change, vecs[v].he, vecs[v].d);
      check_result($sformatf("vec%0d", v), vecs[v].err, vecs[v].rem, vecs[v].done_cyc);
      check($sformatf("vec%0d_ncoins_tbl", v), got_q.size(), vecs[v].ncoins);
      if (vecs[v].ncoins > 0) begin
        check($sformatf("vec%0d_first_eject", v), first_ej, 2);
        if (got_q.size() > 0) check($sformatf("vec%0d_first_type", v), got_q[0],
                                    vecs[v].first_type);
      end else begin
        check($sformatf("vec%0d_no_eject", v), first_ej, -1);
      end
      if (vecs[v].d < 0 && vecs[v].ncoins > 0)
        check($sformatf("vec%0d_eject_run", v), max_run, AckTimeout);
    end

    // Reset while a coin is being ejected.
    dif.change_in    = 16'd25;
    dif.hopper_empty = 4'b0000;
    dif.dispense_req = 1'b1;
    @(posedge clk); #1;
    dif.dispense_req = 1'b0;
    @(posedge clk); #1;
    check("midreset_eject_high", int'(dif.coin_eject), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    ref_model(100, 4'b0000, 0, m_err, m_rem, m_dcyc);
    run_txn(100, 4'b0000, 0);
    check_result("after_reset", m_err, m_rem, m_dcyc);

    // Request held high while busy, ack held high outside eject: one payout only.
    dif.change_in    = 16'd50;
    dif.hopper_empty = 4'b0000;
    dif.coin_ack     = 1'b1;
    dif.dispense_req = 1'b1;
    @(posedge clk); #1;
    ejects  = 0;
    done_k  = -1;
    prev_ej = 1'b0;
    for (int k = 1; k <= 100 && done_k < 0; k++) begin
      if (dif.coin_eject && !prev_ej) ejects++;
      prev_ej = dif.coin_eject;
      if (dif.done) done_k = k;
      else begin
        @(posedge clk); #1;
      end
    end
    dif.dispense_req = 1'b0;
    dif.coin_ack     = 1'b0;
    check("busy_req_done_cycle", done_k, 6);
    check("busy_req_ejects", ejects, 2);
    busy_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (dif.busy) busy_seen = 1'b1;
    end
    check("busy_req_not_queued", int'(busy_seen), 0);
    check("busy_req_remaining", int'(dif.remaining), 0);

    // Random requests against the model.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, 1100));
      else c = 5 * int'($urandom_range(0, 100));
      he = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d = -1;
      else d = int'($urandom_range(0, 2));
      ref_model(c, he, d, m_err, m_rem, m_dcyc);
      run_txn(c, he, d);
      check_result($sformatf("rand%0d_c%0d", n, c), m_err, m_rem, m_dcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
